// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte valid/ready handshake feeding the UART transmitter FIFO.
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    modport master (output tx_data, tx_valid, input tx_ready);
    modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter with host clear-to-send gating.
module uart_tx_fifo #(
    parameter int CLK_DIV = 868,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    uart_tx_fifo_if.slave            tx,
    input  logic                     cts_n_i,
    output logic                     txd_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state_q;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    cts_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    sh_q;
    logic          txd_q, push, pop, bit_end;
    assign tx.tx_ready  = count_q != (AW+1)'(DEPTH);
    assign push         = tx.tx_valid && tx.tx_ready;
    assign bit_end      = cnt_q == CNT_MAX;
    // A frame starts from IDLE or straight out of a finished stop bit, so back-to-back frames have no gap
    assign pop          = (state_q == IDLE || (state_q == STOP && bit_end)) && count_q != '0 && !cts_q[1];
    assign count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
    assign txd_o        = txd_q;
    assign busy_o       = state_q != IDLE;
    assign fifo_count_o = count_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cts_q    <= 2'b11;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_d;
            cts_q    <= {cts_q[0], cts_n_i};
        end
    always_ff @(posedge clk)
        if (push) mem_q[wr_ptr_q] <= tx.tx_data;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
        end else if (pop) begin
            state_q <= START;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= mem_q[rd_ptr_q];
            txd_q   <= 1'b0;
        end else if (state_q != IDLE) begin
            cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
            if (bit_end)
                case (state_q)
                    START: begin
                        state_q <= DATA;
                        txd_q   <= sh_q[0];
                        sh_q    <= sh_q >> 1;
                    end
                    DATA: if (idx_q == 3'd7) begin
                        state_q <= STOP;
                        txd_q   <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                        txd_q <= sh_q[0];
                        sh_q  <= sh_q >> 1;
                    end
                    default: state_q <= IDLE;
                endcase
        end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmitter: the transmit counterpart of the board's 115200-baud receive path. It accepts bytes over a valid/ready handshake into a small FIFO and serialises them as 8N1 frames on the USB-UART line toward the host, honouring the host's clear-to-send. It sits beside the receiver in the top level and drives `UART_RXD_OUT`; `txd` connects to that pin.

## Interface
- `CLK_DIV`, 868: clock cycles per bit. 100 MHz / 115200 gives 868. Minimum 2.
- `DEPTH`, 4: FIFO entries. Must be a power of two, ≥ 2.

- `clk` in 1: 100 MHz system clock; all state is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: FIFO can accept a byte.
- `cts_n` in 1: host clear-to-send, active-low, asynchronous to `clk`.
- `txd` out 1: serial output, idle high.
- `busy` out 1: a frame is on the wire.
- `fifo_count` out $clog2(DEPTH)+1: bytes queued, excluding the byte being shifted.

## Operation
- **Handshake and FIFO**
  - Push when `tx_valid && tx_ready` at a rising edge.
  - `tx_ready = (fifo_count != DEPTH)`, combinational from the count.
  - A push and a pop in the same cycle leave the count unchanged.
  - When the FIFO is full, `tx_ready` is low even in a cycle that pops.
  - `tx_data` and `tx_valid` are don't-care when not accepted.
- **CTS synchroniser**: `cts_n` passes through a 2-flop synchroniser (`cts_s`). Only `cts_s` is used.
- **FSM states**: IDLE, START, DATA, STOP.
  - IDLE → START when `fifo_count > 0 && cts_s == 0`. That edge pops the head into the shift register, clears the bit counter and the 3-bit bit index, and drives `txd` = 0.
  - START → DATA after `CLK_DIV` cycles, driving bit 0 (LSB first).
  - DATA: each bit is held `CLK_DIV` cycles. After bit 7, go to STOP and drive `txd` = 1.
  - STOP: after `CLK_DIV` cycles, if the START condition holds, go directly to START (pop, `txd` = 0), so there is no idle gap. Otherwise go to IDLE.
- **Flow control**
  - `cts_s` is evaluated only at frame start.
  - Deasserting `cts_n` mid-frame never truncates or stretches the current frame.
- **Outputs**
  - `txd` is driven from a flop, so it is glitch-free.
  - `busy = (state != IDLE)`.
- **Bit counter**: width $clog2(CLK_DIV). It counts 0..CLK_DIV-1 and wraps to 0 at each bit boundary.
- **FIFO pointers**: $clog2(DEPTH) bits each, wrapping naturally modulo `DEPTH`.

## Timing
- **Reset values**: `txd` = 1, `busy` = 0, `fifo_count` = 0, `tx_ready` = 1, state IDLE.
  - Pointers, counters and `cts_s` are cleared; `cts_s` resets to 1 (not clear).
- **Reset mid-frame**: `txd` returns to 1 asynchronously, the queued bytes are discarded, and no partial frame resumes.
- **Latency from acceptance**: let T = the edge that accepts a byte into an empty FIFO, while IDLE with `cts_s` = 0.
  - `txd` falls after edge T+1.
  - Bit i (0..7) starts `(i+1)*CLK_DIV` cycles after the fall.
  - The stop bit starts at `9*CLK_DIV`.
  - The frame ends at `10*CLK_DIV`.
- **CTS release**: a `cts_n` 1→0 transition is seen in `cts_s` after 2 edges. With data queued, `txd` falls on the following edge, i.e. 3 edges after the transition.
- **Back-to-back**: consecutive frames are exactly `10*CLK_DIV` cycles apart.
- **`fifo_count` timing**: decrements on the edge where `txd` falls for each frame.

## Test plan
- **Single byte**: `CLK_DIV`=868, `cts_n`=0, push 0x55.
  - `txd` falls 2 edges after the push, then holds 0,1,0,1,0,1,0,1,0,1.
  - Each level lasts 868 cycles (LSB first; start=0, stop=1).
  - `busy` is high for exactly 8680 cycles.
- **Back-to-back**: `CLK_DIV`=4, push 0x00, 0xFF, 0xA5, 0x3C on consecutive cycles.
  - All 4 are accepted, with `fifo_count` peaking at 3.
  - Four contiguous frames, 40 cycles each, no idle high between stop and next start; decoded bytes match.
- **Backpressure**: `CLK_DIV`=4, `cts_n`=1, push 5 bytes.
  - `tx_ready` drops after the 4th; the 5th is held until `cts_n`=0 and the first pop.
  - The 5th is then accepted and sent last; order is preserved.
- **CTS hold**: `cts_n`=1, push 0x81.
  - `txd` stays 1 indefinitely.
  - Drive `cts_n`=0: `txd` falls on the 3rd edge after the transition.
- **CTS mid-frame**: raise `cts_n` during bit 3 of a frame with 2 bytes queued.
  - The current frame completes intact.
  - No new start bit appears until `cts_n`=0.
- **Reset mid-frame**: assert `rst_n`=0 during bit 5 of a frame, with 2 bytes queued.
  - `txd`=1, `busy`=0, `fifo_count`=0 immediately.
  - After release, `txd` stays idle high and `tx_ready`=1.
